// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 control path.
package ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;

    // Fixed state encoding; code 6 is unused.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        R     = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } iclass_t;

    localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;

    // Map an opcode to its instruction class; NONE marks an unsupported opcode.
    function automatic iclass_t decode_class(input logic [OPCODE_W-1:0] op);
        iclass_t c;
        case (op)
            OP_R:     c = R;
            OP_LOAD:  c = LOAD;
            OP_STORE: c = STORE;
            default:  c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles a memory request waits for its ack; flags expiry in the limit cycle.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic nReset,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Wait counter: cleared when a new request phase starts, advances while stalled.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (busy && !ack) begin
            count <= count + CNT_W'(1);
        end
    end

    // An ack in the limit cycle completes normally, so it suppresses expiry.
    assign expire = busy && !ack && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing for the RV32 datapath.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned RET_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_sel,
    output logic                ir_en,
    output logic                pc_en,
    output logic                regw,
    output logic                wb_sel,
    output logic                alu_src,
    output logic                illegal,
    output logic                timeout,
    output logic [STATE_W-1:0]  state,
    output logic [RET_W-1:0]    retired
);

    state_t  state_q;
    state_t  state_d;
    iclass_t cls_q;
    iclass_t dec_cls;
    logic    set_illegal;
    logic    wd_busy;
    logic    wd_clr;
    logic    wd_expire;

    assign dec_cls = decode_class(opcode);
    assign state   = state_q;

    // Watchdog watches the two request states; it restarts on entry to either.
    assign wd_busy = (state_q == FETCH) || (state_q == MEM);
    assign wd_clr  = ((state_d == FETCH) || (state_d == MEM)) && (state_d != state_q);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .nReset (nReset),
        .clr    (wd_clr),
        .busy   (wd_busy),
        .ack    (mem_ack),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode (Moore per state, Mealy on mem_ack).
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        regw        = 1'b0;
        wb_sel      = 1'b0;
        alu_src     = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    state_d = DECODE;
                end else if (wd_expire) begin
                    state_d = TRAP;
                end
            end
            DECODE: begin
                if (dec_cls == NONE) begin
                    set_illegal = 1'b1;
                    state_d     = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_src = (cls_q != R);
                state_d = (cls_q == R) ? WB : MEM;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cls_q == STORE);
                alu_src = 1'b1;
                if (mem_ack) begin
                    if (cls_q == STORE) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_expire) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                regw    = 1'b1;
                wb_sel  = (cls_q == LOAD);
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction class is captured once per instruction while the opcode is stable.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cls_q <= NONE;
        end else if (state_q == DECODE) begin
            cls_q <= dec_cls;
        end
    end

    // Sticky trap causes; only reset clears them.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (wd_expire) begin
                timeout <= 1'b1;
            end
        end
    end

    // Retired-instruction counter: one count per PC advance, wraps freely.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            retired <= '0;
        end else if (pc_en) begin
            retired <= retired + RET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: R/LOAD/STORE flows, illegal trap, watchdog, async reset.
module tb_multicycle_ctrl;

    localparam int unsigned RET_W = 32;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    // Strobe vector bit weights: {mem_req, mem_we, mem_sel, ir_en, pc_en, regw, wb_sel, alu_src}
    localparam logic [7:0] REQ = 8'h80;
    localparam logic [7:0] WE  = 8'h40;
    localparam logic [7:0] SEL = 8'h20;
    localparam logic [7:0] IR  = 8'h10;
    localparam logic [7:0] PC  = 8'h08;
    localparam logic [7:0] RW  = 8'h04;
    localparam logic [7:0] WBS = 8'h02;
    localparam logic [7:0] ALU = 8'h01;

    logic             clk;
    logic             nReset;
    logic [6:0]       opcode;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel;
    logic             ir_en;
    logic             pc_en;
    logic             regw;
    logic             wb_sel;
    logic             alu_src;
    logic             illegal;
    logic             timeout;
    logic [2:0]       state;
    logic [RET_W-1:0] retired;
    logic [7:0]       strb;

    int n_assert = 0;
    int n_fail   = 0;

    assign strb = {mem_req, mem_we, mem_sel, ir_en, pc_en, regw, wb_sel, alu_src};

    multicycle_ctrl #(
        .RET_W   (RET_W),
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .nReset  (nReset),
        .opcode  (opcode),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .mem_sel (mem_sel),
        .ir_en   (ir_en),
        .pc_en   (pc_en),
        .regw    (regw),
        .wb_sel  (wb_sel),
        .alu_src (alu_src),
        .illegal (illegal),
        .timeout (timeout),
        .state   (state),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [2:0] es, input logic [7:0] eb);
        #1;
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_strb"}, 32'(strb), 32'(eb));
    endtask

    task automatic flags(input string tag, input logic il, input logic to);
        chk({tag, "_illegal"}, 32'(illegal), 32'(il));
        chk({tag, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        nReset  = 1'b0;
        opcode  = 7'd0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 3'd0, 8'h00);
        chk("reset_retired", retired, 32'd0);
        flags("reset", 1'b0, 1'b0);

        // R-type with immediate acks: IDLE, FETCH, DECODE, EXEC, WB, FETCH
        nReset = 1'b1;
        look("idle", 3'd0, 8'h00);
        opcode  = OPC_R;
        mem_ack = 1'b1;
        tick(); look("r_fetch", 3'd1, REQ | IR);
        tick(); look("r_decode", 3'd2, 8'h00);
        tick(); look("r_exec", 3'd3, 8'h00);
        tick(); look("r_wb", 3'd5, PC | RW);
        chk("r_retired_pre", retired, 32'd0);
        tick(); opcode = OPC_LOAD; look("r_next", 3'd1, REQ | IR);
        chk("r_retired", retired, 32'd1);

        // LOAD with ack arriving in the third MEM cycle
        tick(); mem_ack = 1'b0; look("ld_decode", 3'd2, 8'h00);
        tick(); look("ld_exec", 3'd3, ALU);
        tick(); look("ld_mem1", 3'd4, REQ | SEL | ALU);
        tick(); look("ld_mem2", 3'd4, REQ | SEL | ALU);
        tick(); mem_ack = 1'b1; look("ld_mem3", 3'd4, REQ | SEL | ALU);
        tick(); look("ld_wb", 3'd5, PC | RW | WBS);
        chk("ld_retired_pre", retired, 32'd1);
        flags("ld", 1'b0, 1'b0);
        tick(); opcode = OPC_STORE; look("ld_next", 3'd1, REQ | IR);
        chk("ld_retired", retired, 32'd2);

        // STORE: pc_en only on the MEM ack cycle, never regw
        tick(); mem_ack = 1'b0; look("st_decode", 3'd2, 8'h00);
        tick(); look("st_exec", 3'd3, ALU);
        tick(); look("st_mem_wait", 3'd4, REQ | WE | SEL | ALU);
        mem_ack = 1'b1;
        look("st_mem_ack", 3'd4, REQ | WE | SEL | ALU | PC);
        tick(); mem_ack = 1'b0; look("st_next", 3'd1, REQ);
        chk("st_retired", retired, 32'd3);

        // Ack in the watchdog limit cycle (4th FETCH cycle) completes normally
        tick(); look("wd_f2", 3'd1, REQ);
        tick(); look("wd_f3", 3'd1, REQ);
        tick(); mem_ack = 1'b1; opcode = OPC_BAD; look("wd_f4", 3'd1, REQ | IR);
        flags("wd_f4", 1'b0, 1'b0);

        // Illegal opcode traps; later acks are ignored
        tick(); mem_ack = 1'b0; look("ill_decode", 3'd2, 8'h00);
        flags("ill_decode", 1'b0, 1'b0);
        tick(); look("ill_trap", 3'd7, 8'h00);
        flags("ill_trap", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); mem_ack = 1'b1; look("trap_ack", 3'd7, 8'h00);
            tick(); mem_ack = 1'b0; look("trap_idle", 3'd7, 8'h00);
        end
        chk("trap_retired", retired, 32'd3);
        flags("trap_hold", 1'b1, 1'b0);

        // Reset clears everything, then FETCH never acked trips the watchdog
        nReset = 1'b0;
        look("rst2", 3'd0, 8'h00);
        chk("rst2_retired", retired, 32'd0);
        flags("rst2", 1'b0, 1'b0);
        tick(); nReset = 1'b1; opcode = OPC_R; mem_ack = 1'b0;
        look("to_idle", 3'd0, 8'h00);
        tick(); look("to_f1", 3'd1, REQ);
        tick(); look("to_f2", 3'd1, REQ);
        tick(); look("to_f3", 3'd1, REQ);
        tick(); look("to_f4", 3'd1, REQ);
        flags("to_f4", 1'b0, 1'b0);
        tick(); look("to_trap", 3'd7, 8'h00);
        flags("to_trap", 1'b0, 1'b1);

        // Async reset in the MEM phase of a load abandons the request immediately
        nReset = 1'b0;
        tick(); nReset = 1'b1;
        look("ar_idle", 3'd0, 8'h00);
        opcode  = OPC_LOAD;
        mem_ack = 1'b1;
        tick(); look("ar_fetch", 3'd1, REQ | IR);
        tick(); mem_ack = 1'b0; look("ar_decode", 3'd2, 8'h00);
        tick(); look("ar_exec", 3'd3, ALU);
        tick(); look("ar_mem", 3'd4, REQ | SEL | ALU);
        nReset = 1'b0;
        look("ar_async", 3'd0, 8'h00);
        tick();
        tick(); nReset = 1'b1;
        look("ar_release", 3'd0, 8'h00);
        flags("ar_release", 1'b0, 1'b0);
        chk("ar_retired", retired, 32'd0);
        tick(); look("ar_refetch", 3'd1, REQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL time_limit: bench did not complete within bound");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32 core datapath through fetch, decode, execute, memory and writeback.
- Generates the strobes around the instruction decoder, ALU, register file and shared memory port:
  - IR load
  - PC increment
  - register write
  - memory request/write
  - mux selects
- Includes a memory-handshake watchdog, a sticky illegal-opcode trap and a retired-instruction counter.

Parameters:
- RET_W, 32: width of retired-instruction counter.
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before trapping (legal range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from IR; stable from DECODE onward.
- mem_ack  in  1  memory completion for current request; read data valid in same cycle.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable (store data phase).
- mem_sel  out  1  address mux: 0 = PC (fetch), 1 = ALU result (data).
- ir_en  out  1  load IR with read data.
- pc_en  out  1  PC += 4 (decoder "incr" path).
- regw  out  1  register-file write enable.
- wb_sel  out  1  writeback mux: 0 = ALU, 1 = load data.
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- illegal  out  1  sticky: unsupported opcode decoded.
- timeout  out  1  sticky: memory watchdog expired.
- state  out  3  current state encoding (debug).
- retired  out  RET_W  count of completed instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async, nReset low):
  - state = IDLE; class = NONE.
  - retired = 0; illegal = 0; timeout = 0; watchdog = 0.
  - All strobes are Moore-decoded from IDLE, so all are 0.
- IDLE: all strobes 0; unconditional -> FETCH next cycle.
- FETCH:
  - mem_req = 1, mem_sel = 0, mem_we = 0.
  - On mem_ack: ir_en = 1 (Mealy, same cycle), -> DECODE.
- DECODE:
  - 1 cycle; latch class from opcode:
    - 0110011 -> R
    - 0000011 -> LOAD
    - 0100011 -> STORE
    - anything else: illegal <= 1, -> TRAP.
  - Legal class -> EXEC.
- EXEC:
  - 1 cycle; alu_src = 0 for R, 1 for LOAD/STORE.
  - R -> WB; LOAD/STORE -> MEM.
- MEM:
  - mem_req = 1, mem_sel = 1, mem_we = (class == STORE); alu_src held at 1.
  - On mem_ack:
    - LOAD -> WB.
    - STORE: pc_en = 1 (Mealy), -> FETCH.
- WB:
  - regw = 1, wb_sel = (class == LOAD), pc_en = 1; -> FETCH.
- TRAP:
  - All strobes 0; remains until reset.
- Minimum latencies with ack in the first request cycle:
  - R = 4 cycles (FETCH, DECODE, EXEC, WB).
  - STORE = 4 cycles.
  - LOAD = 5 cycles.
- Watchdog:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_req = 1 and mem_ack = 0.
  - When count == TIMEOUT-1 and mem_ack = 0: timeout <= 1, -> TRAP.
  - mem_ack arriving in the limit cycle wins: normal transition, no trap.
- retired:
  - Increments on every cycle pc_en = 1.
  - Wraps modulo 2^RET_W; no saturation.
- mem_ack outside FETCH/MEM is ignored; no state change.
- pc_en, regw and ir_en never assert together with illegal/timeout set.
- Reset asserted mid-instruction: immediate return to IDLE; in-flight request is abandoned (mem_req drops asynchronously).
- state encoding, fixed:
  - IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (encoding above)
  - iclass_t enum {NONE, R, LOAD, STORE}
  - opcode constants OP_R, OP_LOAD, OP_STORE
- Sub-module mem_watchdog (TIMEOUT parameter): inputs clk, nReset, clr, busy, ack; output expire.
  - Separately instanced and tested.

Test Plan:
- Release reset, opcode = 0110011, mem_ack high every request -> state sequence 0,1,2,3,5,1; ir_en in cycle 1; regw = 1, pc_en = 1 in cycle 4; retired = 1.
- Load, opcode = 0000011, mem_ack delayed 3 cycles in MEM -> mem_req/mem_sel = 1 for 3 cycles; WB with wb_sel = 1, regw = 1; retired increments once.
- Store, opcode = 0100011 -> MEM has mem_we = 1; pc_en pulses on the ack cycle; regw never asserts; next state FETCH.
- opcode = 1111111 in DECODE -> illegal = 1, state = 7; further mem_ack pulses produce no strobes; retired unchanged.
- TIMEOUT = 4, mem_ack held low in FETCH:
  - timeout = 1 and TRAP after the 4th request cycle.
  - Repeat with ack on the 4th cycle -> no trap.
- Assert nReset low during MEM of a load -> mem_req drops asynchronously; after release: IDLE, then FETCH; illegal, timeout and retired all 0.
